// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain half of an async FIFO: binary/Gray write pointers, read-pointer
// synchroniser, and registered full / almost-full / overflow / fill-level status.
module async_fifo_wr_ctrl #(
    parameter int FIFO_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = FIFO_DEPTH - 2,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                  wr_clk_i,
    input  logic                  wr_rst_i,
    input  logic                  wr_en_i,
    input  logic [FIFO_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W:0]       rd_ptr_gray_i,
    output logic                  mem_wr_valid_o,
    output logic [ADDR_W-1:0]     mem_wr_addr_o,
    output logic [FIFO_WIDTH-1:0] mem_wr_data_o,
    output logic [ADDR_W:0]       wr_ptr_gray_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  overflow_o,
    output logic [ADDR_W:0]       wr_count_o
);

    localparam logic [ADDR_W:0] AF_LVL = AF_LEVEL[ADDR_W:0];

    logic [ADDR_W:0] wbin_q, wbin_d;
    logic [ADDR_W:0] wgray_q, wgray_d;
    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] rq, rbin;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            full_q, full_d;
    logic            af_q, af_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    assign rq = sync_q[SYNC_STAGES-1];

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(rq >> i);
        end
    end

    // Full compares against the stale synchronised read pointer, so it can only
    // be late to clear, never late to set.
    always_comb begin
        accept  = wr_en_i & ~full_q;
        wbin_d  = wbin_q + {{ADDR_W{1'b0}}, accept};
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        full_d  = (wgray_d == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});
        cnt_d   = wbin_d - rbin;
        af_d    = (cnt_d >= AF_LVL);
        ovf_d   = wr_en_i & full_q;
    end

    always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
        if (wr_rst_i) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            sync_q[0] <= rd_ptr_gray_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign mem_wr_valid_o = accept;
    assign mem_wr_addr_o  = wbin_q[ADDR_W-1:0];
    assign mem_wr_data_o  = wr_data_i;
    assign wr_ptr_gray_o  = wgray_q;
    assign full_o         = full_q;
    assign almost_full_o  = af_q;
    assign overflow_o     = ovf_q;
    assign wr_count_o     = cnt_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl: memory writes checked by a scoreboard
// monitor, status outputs checked against hand-computed values.
module tb_async_fifo_wr_ctrl;

    localparam int W = 8;
    localparam int D = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic [A:0]   rd_gray;
    logic         mvalid;
    logic [A-1:0] maddr;
    logic [W-1:0] mdata;
    logic [A:0]   wgray;
    logic         full, afull, ovf;
    logic [A:0]   cnt;

    int n_vec = 0;
    int n_bad = 0;
    logic [A+W-1:0] exp_q [$];

    always #5 clk = ~clk;

    async_fifo_wr_ctrl #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .SYNC_STAGES(2), .AF_LEVEL(6)) dut (
        .wr_clk_i(clk), .wr_rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .rd_ptr_gray_i(rd_gray), .mem_wr_valid_o(mvalid), .mem_wr_addr_o(maddr),
        .mem_wr_data_o(mdata), .wr_ptr_gray_o(wgray), .full_o(full),
        .almost_full_o(afull), .overflow_o(ovf), .wr_count_o(cnt)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [A-1:0] addr, input logic [W-1:0] data);
        wr_en   = 1'b1;
        wr_data = data;
        exp_q.push_back({addr, data});
    endtask

    function automatic logic [A:0] b2g(input logic [A:0] b);
        return b ^ (b >> 1);
    endfunction

    // Monitor: every memory write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mvalid === 1'b1) begin
            logic [A+W-1:0] e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL mem_wr unexpected: addr %0d data %0h, expected no write", maddr, mdata);
            end else begin
                e = exp_q.pop_front();
                if ({maddr, mdata} !== e) begin
                    n_bad++;
                    $display("FAIL mem_wr: addr %0d data %0h expected addr %0d data %0h",
                             maddr, mdata, e[A+W-1:W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_gray = '0;
        #2;
        chk("rst_valid", mvalid, 0);
        chk("rst_gray", wgray, 0);
        chk("rst_full", full, 0);
        chk("rst_count", cnt, 0);
        chk("rst_addr", maddr, 0);
        step();
        rst = 1'b0;

        // 1: fill from empty
        for (int i = 0; i < 8; i++) begin
            push_wr(i[A-1:0], 8'hA0 + i[W-1:0]);
            step();
        end
        wr_en = 1'b0;
        chk("t1_full", full, 1);
        chk("t1_count", cnt, 8);
        chk("t1_gray", wgray, 4'b1100);
        chk("t1_afull", afull, 1);
        chk("t1_ovf", ovf, 0);

        // 2: write while full
        wr_en = 1'b1; wr_data = 8'h55;
        #1;
        chk("t2_valid", mvalid, 0);
        step();
        wr_en = 1'b0;
        chk("t2_ovf_pulse", ovf, 1);
        chk("t2_gray", wgray, 4'b1100);
        step();
        chk("t2_ovf_clear", ovf, 0);
        chk("t2_count", cnt, 8);

        // 3: remote read to bin 3, full clears after 3 edges
        rd_gray = 4'b0010;
        step(); chk("t3_full_e1", full, 1);
        step(); chk("t3_full_e2", full, 1);
        step(); chk("t3_full_e3", full, 0);
        chk("t3_count", cnt, 5);
        chk("t3_afull", afull, 0);

        // 4: cross almost-full threshold
        push_wr(3'd0, 8'h66);
        step();
        chk("t4_count6", cnt, 6);
        chk("t4_afull6", afull, 1);
        push_wr(3'd1, 8'h67);
        step();
        wr_en = 1'b0;
        chk("t4_count7", cnt, 7);
        chk("t4_afull7", afull, 1);
        chk("t4_full7", full, 0);

        // 5: 16-write stream from reset, read pointer trailing by 2
        rst = 1'b1; rd_gray = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_gray = (i >= 2) ? b2g(4'(i - 2)) : '0;
            push_wr(i[A-1:0], i[W-1:0]);
            step();
            chk("t5_no_ovf", ovf, 0);
        end
        wr_en = 1'b0;
        chk("t5_gray_wrap", wgray, 0);
        chk("t5_full", full, 0);

        // 6: reset asserted between edges mid-burst
        for (int i = 0; i < 3; i++) begin
            push_wr(i[A-1:0], 8'hC0 + i[W-1:0]);
            step();
        end
        wr_en = 1'b0; rst = 1'b1; rd_gray = '0;
        #1;
        chk("t6_valid", mvalid, 0);
        chk("t6_addr", maddr, 0);
        chk("t6_gray", wgray, 0);
        chk("t6_full", full, 0);
        chk("t6_afull", afull, 0);
        chk("t6_ovf", ovf, 0);
        chk("t6_count", cnt, 0);
        step();
        rst = 1'b0;
        push_wr(3'd0, 8'h99);
        step();
        wr_en = 1'b0;
        chk("t6_gray1", wgray, 4'b0001);
        chk("t6_count1", cnt, 1);
        step();

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
